// File: rtl/hilo_if.sv
// hilo_if: bundles the hilo_unit request, mt-write, multiplier-side and
// result signals into one port.
//   master : control unit / bench side (drives requests and multiplier results)
//   slave  : hilo_unit side (drives multiplier controls and HI/LO status)
interface hilo_if #(parameter int WIDTH = 32);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             hi_wr;
   logic             lo_wr;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] mult_hi;
   logic [WIDTH-1:0] mult_lo;
   logic             mult_ctrl;
   logic [WIDTH-1:0] mult_a;
   logic [WIDTH-1:0] mult_b;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;
   logic             busy;
   logic             done;

   modport master (
      output start, a_in, b_in, hi_wr, lo_wr, wr_data, mult_hi, mult_lo,
      input  mult_ctrl, mult_a, mult_b, hi_out, lo_out, busy, done
   );

   modport slave (
      input  start, a_in, b_in, hi_wr, lo_wr, wr_data, mult_hi, mult_lo,
      output mult_ctrl, mult_a, mult_b, hi_out, lo_out, busy, done
   );
endinterface

// File: rtl/hilo_unit.sv
// hilo_unit: sequences the Booth multiplier and holds architectural HI/LO.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus.start/a_in/b_in     : one-cycle multiply request and operands
//   bus.hi_wr/lo_wr/wr_data : mthi/mtlo writes (accepted only in IDLE)
//   bus.mult_hi/mult_lo     : product from the multiplier
//   bus.mult_ctrl/mult_a/mult_b : multiplier enable and held operands
//   bus.hi_out/lo_out       : architectural HI/LO
//   bus.busy/done           : in-flight flag and one-cycle completion pulse
// All outputs are registered: next values are formed in the comb process
// and loaded in the single sequential process.
module hilo_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 33
) (
   input logic  clk,
   input logic  reset,
   hilo_if.slave bus
);
   localparam int CNT_W = (MULT_CYCLES > 2) ? $clog2(MULT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [WIDTH-1:0] mult_a, mult_a_n;
   logic [WIDTH-1:0] mult_b, mult_b_n;
   logic [WIDTH-1:0] hi, hi_n;
   logic [WIDTH-1:0] lo, lo_n;
   logic             ctrl, ctrl_n;
   logic             busy, busy_n;
   logic             done, done_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         mult_a <= '0;
         mult_b <= '0;
         hi     <= '0;
         lo     <= '0;
         ctrl   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         mult_a <= mult_a_n;
         mult_b <= mult_b_n;
         hi     <= hi_n;
         lo     <= lo_n;
         ctrl   <= ctrl_n;
         busy   <= busy_n;
         done   <= done_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      mult_a_n = mult_a;
      mult_b_n = mult_b;
      hi_n     = hi;
      lo_n     = lo;
      done_n   = 1'b0;
      case (state)
         IDLE: begin
            // mt writes and start may coincide; the product later overwrites.
            if (bus.hi_wr) hi_n = bus.wr_data;
            if (bus.lo_wr) lo_n = bus.wr_data;
            if (bus.start) begin
               mult_a_n = bus.a_in;
               mult_b_n = bus.b_in;
               cnt_n    = '0;
               state_n  = RUN;
            end
         end
         RUN: begin
            // cnt counts enable edges already seen; the last one moves to CAPTURE.
            if (cnt == CNT_LAST) state_n = CAPTURE;
            else                 cnt_n   = cnt + 1'b1;
         end
         CAPTURE: begin
            hi_n    = bus.mult_hi;
            lo_n    = bus.mult_lo;
            done_n  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // Registered from the next state so the enable tracks RUN exactly.
      ctrl_n = (state_n == RUN);
      busy_n = (state_n != IDLE);
   end

   assign bus.mult_ctrl = ctrl;
   assign bus.mult_a    = mult_a;
   assign bus.mult_b    = mult_b;
   assign bus.hi_out    = hi;
   assign bus.lo_out    = lo;
   assign bus.busy      = busy;
   assign bus.done      = done;
endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: a 33-cycle multiplier model, a result scoreboard,
// a vector table of multiplies and hand sequences for the corner cases.
module tb_hilo_unit;
   localparam int MC = 33;

   logic clk;
   logic reset;
   hilo_if #(.WIDTH(32)) bus ();

   hilo_unit #(.WIDTH(32), .MULT_CYCLES(MC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;
   logic [63:0] sb[$];

   // Multiplier model: load at first enabled edge, product on the 33rd.
   int step = 0;
   logic [31:0] la, lb;
   function automatic logic [63:0] smul(input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] p;
      p = $signed(x) * $signed(y);
      return p;
   endfunction

   always @(posedge clk) begin
      if (bus.mult_ctrl !== 1'b1) step <= 0;
      else begin
         if (step == 0) begin
            la <= bus.mult_a;
            lb <= bus.mult_b;
            bus.mult_hi <= 32'hA5A5A5A5;
            bus.mult_lo <= 32'h5A5A5A5A;
         end else if (step == MC - 1) begin
            {bus.mult_hi, bus.mult_lo} <= smul(la, lb);
         end else begin
            bus.mult_hi <= 32'hA5A5A5A5;
            bus.mult_lo <= 32'h5A5A5A5A;
         end
         step <= step + 1;
      end
   end

   // Run-length monitor for mult_ctrl and busy (pre-edge values).
   int ctrl_cur = 0, ctrl_last = 0, busy_cur = 0, busy_last = 0;
   always @(posedge clk) begin
      if (bus.mult_ctrl === 1'b1) ctrl_cur++;
      else if (ctrl_cur != 0) begin ctrl_last = ctrl_cur; ctrl_cur = 0; end
      if (bus.busy === 1'b1) busy_cur++;
      else if (busy_cur != 0) begin busy_last = busy_cur; busy_cur = 0; end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
      bus.start = 1'b1;
      bus.a_in  = a;
      bus.b_in  = b;
      sb.push_back(exp);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a_in  = $urandom;
      bus.b_in  = $urandom;
   endtask

   // Leaves the caller at the negedge inside the done cycle.
   task automatic wait_done(input string name);
      int n;
      logic [63:0] e;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.done !== 1'b1 && n < 200);
      if (bus.done !== 1'b1) begin
         n_chk++;
         $display("FAIL %s timeout: got no done expected done within 200 cycles", name);
      end else if (sb.size() == 0) begin
         n_chk++;
         $display("FAIL %s: got done expected no pending result", name);
      end else begin
         e = sb.pop_front();
         chk({name, " hi"}, {32'h0, bus.hi_out}, {32'h0, e[63:32]});
         chk({name, " lo"}, {32'h0, bus.lo_out}, {32'h0, e[31:0]});
      end
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   initial begin
      vec_t vt[6];
      logic [31:0] hi_save;
      int nd;
      vt[0] = '{32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};
      vt[1] = '{32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
      vt[2] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vt[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      vt[4] = '{32'h7FFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFE};
      vt[5] = '{32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

      // Reset held with random inputs, including start and mt writes.
      reset = 1'b1;
      bus.start = 1'b1; bus.hi_wr = 1'b1; bus.lo_wr = 1'b1;
      bus.a_in = $urandom; bus.b_in = $urandom; bus.wr_data = $urandom;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst mult_ctrl", {63'h0, bus.mult_ctrl}, 64'h0);
      chk("rst busy",      {63'h0, bus.busy},      64'h0);
      chk("rst done",      {63'h0, bus.done},      64'h0);
      chk("rst mult_a",    {32'h0, bus.mult_a},    64'h0);
      chk("rst mult_b",    {32'h0, bus.mult_b},    64'h0);
      chk("rst hi",        {32'h0, bus.hi_out},    64'h0);
      chk("rst lo",        {32'h0, bus.lo_out},    64'h0);
      reset = 1'b0;
      bus.start = 1'b0; bus.hi_wr = 1'b0; bus.lo_wr = 1'b0;
      @(negedge clk);
      chk("idle busy", {63'h0, bus.busy}, 64'h0);

      // Vector table.
      for (int i = 0; i < 6; i++) begin
         issue(vt[i].a, vt[i].b, {vt[i].hi, vt[i].lo});
         wait_done($sformatf("vec%0d", i));
         @(negedge clk);
         chk($sformatf("vec%0d done pulse", i), {63'h0, bus.done}, 64'h0);
         chk($sformatf("vec%0d busy len", i), 64'(busy_last), 64'd34);
         chk($sformatf("vec%0d ctrl len", i), 64'(ctrl_last), 64'd33);
      end

      // mthi in IDLE.
      bus.hi_wr = 1'b1; bus.wr_data = 32'hDEADBEEF;
      @(posedge clk); #1 bus.hi_wr = 1'b0;
      @(negedge clk);
      chk("mthi", {32'h0, bus.hi_out}, {32'h0, 32'hDEADBEEF});

      // start with mtlo in the same cycle.
      bus.lo_wr = 1'b1; bus.wr_data = 32'h00001234;
      issue(32'd7, 32'd6, 64'h0000_0000_0000_002A);
      bus.lo_wr = 1'b0;
      @(negedge clk);
      chk("mtlo with start", {32'h0, bus.lo_out}, 64'h1234);
      repeat (32) @(negedge clk);
      chk("mtlo held late", {32'h0, bus.lo_out}, 64'h1234);
      wait_done("start+mtlo");
      @(negedge clk);

      // start/hi_wr while busy are ignored.
      hi_save = bus.hi_out;
      issue(32'h12345678, 32'h00000010, 64'h0000_0001_2345_6780);
      repeat (10) @(negedge clk);
      bus.start = 1'b1; bus.hi_wr = 1'b1;
      bus.a_in = 32'hFFFF0000; bus.b_in = 32'h0000EEEE; bus.wr_data = 32'hCAFEF00D;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.hi_wr = 1'b0;
      @(negedge clk);
      chk("busy mult_a", {32'h0, bus.mult_a}, 64'h12345678);
      chk("busy mult_b", {32'h0, bus.mult_b}, 64'h10);
      chk("busy hi_wr",  {32'h0, bus.hi_out}, {32'h0, hi_save});
      wait_done("illegal");
      @(negedge clk);
      chk("illegal busy len", 64'(busy_last), 64'd34);
      chk("illegal ctrl len", 64'(ctrl_last), 64'd33);
      chk("illegal no requeue", {63'h0, bus.busy}, 64'h0);

      // Reset at cycle 20 of RUN.
      issue(32'h55, 32'h3, 64'hFF);
      repeat (20) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst ctrl", {63'h0, bus.mult_ctrl}, 64'h0);
      chk("midrst busy", {63'h0, bus.busy},      64'h0);
      chk("midrst hi",   {32'h0, bus.hi_out},    64'h0);
      chk("midrst lo",   {32'h0, bus.lo_out},    64'h0);
      sb.delete();
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1) nd++;
      end
      chk("midrst no done", 64'(nd), 64'h0);

      // Back-to-back: second start issued in the done cycle.
      issue(32'hFFFFFFF9, 32'h00000009, 64'hFFFF_FFFF_FFFF_FFC1);
      wait_done("b2b first");
      issue(32'h00000100, 32'hFFFFFF00, 64'hFFFF_FFFF_FFFF_0000);
      wait_done("b2b second");
      @(negedge clk);
      chk("b2b busy len", 64'(busy_last), 64'd34);
      chk("b2b ctrl len", 64'(ctrl_last), 64'd33);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
